// File: rtl/phase_sequencer.sv
// phase_sequencer: parametrised instruction-phase generator.
//
// Produces a one-hot phase vector and its binary index for an instruction cycle of
// NUM_PHASES phases (phase 0 is fetch). Supports run enable, stall, flush,
// single-step operation and a wrapping count of completed instruction cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset, highest priority
//   en           in   run enable, sampled only between instructions
//   stall        in   hold the current phase
//   flush        in   restart at phase 0 without retiring (overrides stall)
//   step_mode    in   1 = park after every instruction
//   step         in   single-step trigger pulse
//   phase        out  one-hot active phase, zero when not running (registered)
//   phase_idx    out  binary index of active phase, zero when not running (registered)
//   running      out  high in RUN (registered)
//   cycle_done   out  last phase completes this cycle (combinational)
//   retire_count out  completed instruction cycles, wraps silently
module phase_sequencer #(
    parameter int unsigned NUM_PHASES = 3,
    parameter int unsigned IDX_W      = $clog2(NUM_PHASES),
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  step_mode,
    input  logic                  step,
    output logic [NUM_PHASES-1:0] phase,
    output logic [IDX_W-1:0]      phase_idx,
    output logic                  running,
    output logic                  cycle_done,
    output logic [CNT_W-1:0]      retire_count
);

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PHASES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStepWait
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_PHASES-1:0]   phase_q, phase_d;
    logic                    running_q, running_d;
    logic [CNT_W-1:0]        retire_q, retire_d;

    // Completion is qualified by every input that would keep the last phase from ending.
    assign cycle_done = running_q & (idx_q == LastIdx) & ~stall & ~flush & ~rst;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        retire_d = retire_q;

        unique case (state_q)
            StIdle: begin
                if (en && (!step_mode || step)) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            StRun: begin
                if (flush) begin
                    idx_d = '0;
                end else if (stall) begin
                    idx_d = idx_q;
                end else if (idx_q != LastIdx) begin
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    // Wrap boundary: the only point where en and step_mode are honoured.
                    retire_d = retire_q + CNT_W'(1);
                    idx_d    = '0;
                    if (step_mode) begin
                        state_d = StStepWait;
                    end else if (!en) begin
                        state_d = StIdle;
                    end
                end
            end
            StStepWait: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (step || !step_mode) begin
                    state_d = StRun;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase

        running_d = (state_d == StRun);
        if (!running_d) begin
            idx_d = '0;
        end
        phase_d = running_d ? (NUM_PHASES'(1) << idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            phase_q   <= '0;
            running_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            running_q <= running_d;
            retire_q  <= retire_d;
        end
    end

    assign phase        = phase_q;
    assign phase_idx    = idx_q;
    assign running      = running_q;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Three-phase instance, 8-bit retire counter.
    logic       rst, en, stall, flush, step_mode, step;
    logic [2:0] phase3;
    logic [1:0] idx3;
    logic       run3, cd3;
    logic [7:0] ret3;

    phase_sequencer #(.NUM_PHASES(3), .CNT_W(8)) u_dut3 (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .stall        (stall),
        .flush        (flush),
        .step_mode    (step_mode),
        .step         (step),
        .phase        (phase3),
        .phase_idx    (idx3),
        .running      (run3),
        .cycle_done   (cd3),
        .retire_count (ret3)
    );

    // Five-phase instance, 2-bit retire counter to exercise the wrap.
    logic       rst5, en5;
    logic       zero5 = 1'b0;
    logic [4:0] phase5;
    logic [2:0] idx5;
    logic       run5, cd5;
    logic [1:0] ret5;

    phase_sequencer #(.NUM_PHASES(5), .CNT_W(2)) u_dut5 (
        .clk          (clk),
        .rst          (rst5),
        .en           (en5),
        .stall        (zero5),
        .flush        (zero5),
        .step_mode    (zero5),
        .step         (zero5),
        .phase        (phase5),
        .phase_idx    (idx5),
        .running      (run5),
        .cycle_done   (cd5),
        .retire_count (ret5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs and combinational cycle_done are settled afterwards.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk3(input string tag, input logic [2:0] ph, input logic [7:0] ret);
        check({tag, ".phase"}, 32'(phase3), 32'(ph));
        check({tag, ".retire"}, 32'(ret3), 32'(ret));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0; flush = 1'b0; step_mode = 1'b0; step = 1'b0;
        rst5 = 1'b1; en5 = 1'b0;
        tick();
        tick();
        check("rst.phase", 32'(phase3), 32'd0);
        check("rst.idx", 32'(idx3), 32'd0);
        check("rst.running", 32'(run3), 32'd0);
        check("rst.retire", 32'(ret3), 32'd0);

        // Free-running: phase 0 for one cycle after en, then 001/010/100 repeating.
        rst = 1'b0;
        en  = 1'b1;
        #1;
        check("start.latency", 32'(phase3), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            chk3("run.p0", 3'b001, 8'(k));
            check("run.idx0", 32'(idx3), 32'd0);
            check("run.cd0", 32'(cd3), 32'd0);
            tick();
            chk3("run.p1", 3'b010, 8'(k));
            check("run.idx1", 32'(idx3), 32'd1);
            tick();
            chk3("run.p2", 3'b100, 8'(k));
            check("run.idx2", 32'(idx3), 32'd2);
            check("run.cd2", 32'(cd3), 32'd1);
            tick();
        end
        chk3("run.retire3", 3'b001, 8'd3);

        // Stall for three edges at 010: holds four cycles total.
        tick();
        chk3("stall.enter", 3'b010, 8'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk3("stall.hold", 3'b010, 8'd3);
        end
        stall = 1'b0;
        tick();
        chk3("stall.release", 3'b100, 8'd3);

        // Flush together with stall on the last phase.
        stall = 1'b1;
        flush = 1'b1;
        #1;
        check("flush.cd", 32'(cd3), 32'd0);
        tick();
        stall = 1'b0;
        flush = 1'b0;
        chk3("flush.restart", 3'b001, 8'd3);

        // Stall on the last phase delays cycle_done.
        tick();
        tick();
        chk3("lstall.p2", 3'b100, 8'd3);
        stall = 1'b1;
        #1;
        check("lstall.cd_held", 32'(cd3), 32'd0);
        tick();
        chk3("lstall.hold", 3'b100, 8'd3);
        stall = 1'b0;
        #1;
        check("lstall.cd_release", 32'(cd3), 32'd1);
        tick();
        chk3("lstall.retire", 3'b001, 8'd4);

        // Drop en mid-instruction: finishes, then IDLE.
        tick();
        chk3("endrop.p1", 3'b010, 8'd4);
        en = 1'b0;
        tick();
        chk3("endrop.p2", 3'b100, 8'd4);
        check("endrop.cd", 32'(cd3), 32'd1);
        tick();
        chk3("endrop.idle", 3'b000, 8'd5);
        check("endrop.running", 32'(run3), 32'd0);
        check("endrop.idx", 32'(idx3), 32'd0);
        tick();
        chk3("endrop.stay", 3'b000, 8'd5);

        // Single-step mode.
        step_mode = 1'b1;
        en = 1'b1;
        tick();
        check("step.no_pulse", 32'(run3), 32'd0);
        for (int s = 0; s < 2; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            chk3("step.p0", 3'b001, 8'(5 + s));
            check("step.running", 32'(run3), 32'd1);
            tick();
            chk3("step.p1", 3'b010, 8'(5 + s));
            step = 1'b1;  // ignored in RUN
            tick();
            step = 1'b0;
            chk3("step.p2", 3'b100, 8'(5 + s));
            check("step.cd", 32'(cd3), 32'd1);
            tick();
            chk3("step.park", 3'b000, 8'(6 + s));
            check("step.parked", 32'(run3), 32'd0);
            tick();
            chk3("step.wait", 3'b000, 8'(6 + s));
        end

        // Leaving step mode from STEP_WAIT resumes free-running.
        step_mode = 1'b0;
        tick();
        chk3("resume.p0", 3'b001, 8'd7);
        check("resume.running", 32'(run3), 32'd1);

        // Five phases, 2-bit counter: retire reads 1,2,3,0,1.
        rst5 = 1'b0;
        en5  = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            for (int p = 0; p < 5; p++) begin
                check("p5.idx", 32'(idx5), 32'(p));
                check("p5.phase", 32'(phase5), 32'(1 << p));
                if (p == 4) check("p5.cd", 32'(cd5), 32'd1);
                tick();
            end
            check("p5.retire", 32'(ret5), 32'((c + 1) % 4));
        end
        tick();
        tick();
        check("p5.idx2", 32'(idx5), 32'd2);
        rst5 = 1'b1;
        tick();
        check("p5rst.phase", 32'(phase5), 32'd0);
        check("p5rst.idx", 32'(idx5), 32'd0);
        check("p5rst.running", 32'(run5), 32'd0);
        check("p5rst.retire", 32'(ret5), 32'd0);
        check("p5rst.cd", 32'(cd5), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Parametrised successor to the fixed three-phase fetch/execute/commit counter.
- Generates a one-hot phase vector with NUM_PHASES phases and a binary phase index.
- Adds run enable, stall, flush, single-step mode and a count of completed instruction cycles.
- Sits at the top of the core and drives all phase-qualified enables in the datapath.

Parameters:
- NUM_PHASES, 3, number of phases per instruction cycle; legal range >= 2; phase 0 is fetch.
- IDX_W, $clog2(NUM_PHASES), width of phase_idx.
- CNT_W, 8, width of retire_count.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable.
- stall  in  1  holds the current phase.
- flush  in  1  restarts at phase 0 without retiring.
- step_mode  in  1  1 = single-step operation.
- step  in  1  single-step trigger; a one-cycle pulse is expected.
- phase  out  NUM_PHASES  one-hot active phase; all zeros when not running.
- phase_idx  out  IDX_W  binary index of the active phase; 0 when not running.
- running  out  1  high in the RUN state.
- cycle_done  out  1  combinational; high when the last phase completes this cycle.
- retire_count  out  CNT_W  number of completed instruction cycles; wraps modulo 2^CNT_W.

Behaviour:
- Reset (already decided): one clock, clk; rst is synchronous and active-high.
  - When rst is sampled high, the block enters IDLE.
  - Reset values: phase = 0, phase_idx = 0, running = 0, retire_count = 0.
  - rst has priority over every other input.
  - Reset mid-cycle abandons the instruction; retire_count is not incremented.
- States:
  - IDLE: no phase active.
  - RUN: phases advance.
  - STEP_WAIT: parked between instructions; no phase active.
- phase, phase_idx and running are registered outputs.
  - In RUN, phase = 1 << phase_idx.
  - In IDLE and STEP_WAIT, phase = 0 and phase_idx = 0.
- IDLE -> RUN when (en & ~step_mode), or when (en & step_mode & step).
  - Next cycle: phase[0] = 1, phase_idx = 0 (latency 1).
- RUN, per-cycle priority: flush > stall > advance.
  - flush: next phase_idx = 0 and the block stays in RUN. No retire, no cycle_done. flush overrides stall.
  - stall (no flush): phase_idx is held.
  - Advance, idx < NUM_PHASES-1: phase_idx increments by 1.
  - Advance, idx = NUM_PHASES-1 (wrap boundary):
    - cycle_done = 1 and retire_count increments.
    - If step_mode = 1: go to STEP_WAIT.
    - Else if en = 0: go to IDLE.
    - Else: phase_idx returns to 0 and the block stays in RUN.
- cycle_done = running & (phase_idx == NUM_PHASES-1) & ~stall & ~flush & ~rst.
- en is only sampled at a wrap boundary; dropping en mid-cycle finishes the current instruction.
- STEP_WAIT:
  - step & en -> RUN at phase 0 on the next cycle.
  - en = 0 -> IDLE.
  - step_mode = 0 & en -> RUN (resume free-running).
  - step is ignored in RUN.
- A stall on the last phase delays cycle_done until the cycle in which the stall is released.
- retire_count increments from 2^CNT_W-1 to 0 with no flag.
- phase is always one-hot or zero; it is never multi-hot.

Test Plan:
- rst=1 for 2 cycles, then en=1 with NUM_PHASES=3:
  - phase is 0 for one cycle, then 001, 010, 100, 001, ...
  - cycle_done is high on each 100 cycle; retire_count reads 1, 2, 3 after the 1st, 2nd and 3rd wraps.
- stall=1 for 3 cycles while phase=010 -> phase holds 010 for 4 cycles total, then advances to 100; retire_count is not affected.
- flush=1 together with stall=1 at phase=100 -> next phase=001, cycle_done=0, retire_count unchanged.
- step_mode=1, single step pulse from IDLE:
  - Response: 001, 010, 100, then phase=0 and running=0; retire_count +1.
  - A second step pulse repeats the sequence; step pulses during RUN have no effect.
- en dropped at phase=010 -> phase continues 100, then IDLE with phase=0; retire_count +1.
- NUM_PHASES=5, CNT_W=2, 5 full cycles:
  - phase_idx runs 0..4 repeatedly.
  - retire_count reads 1, 2, 3, 0, 1.
  - rst asserted at idx 2 -> next cycle all outputs are 0.
